band_gain_mixer: RTL
====================

# band_gain_mixer

Equalizer output stage: captures the outputs of the parallel band filters on each sample strobe, scales each band by a programmable Q`magn`.`decim` gain, sums them with one time-multiplexed multiplier, and saturates the result to the sample width. It sits directly downstream of the band-pass filter bank and shares its clock, sample enable and reset. The gain registers are written by the control logic, for example the user's gain knobs.

## Interface
- `decim`, 14, fractional bits of samples and gains
- `magn`, 8, integer bits of samples and gains
- `N`, `decim+magn+1`, sample/gain width (23), signed two's complement
- `NBANDS`, 4, number of bands (≥2)
- `clock`  in  1  single clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high
- `gen_enable`  in  1  sample strobe, the same one that drives the filters; one-cycle pulse
- `DataBands`  in  NBANDS*N  band outputs, band k at bits [k*N +: N], signed
- `gain_we`  in  1  gain register write strobe
- `gain_addr`  in  clog2(NBANDS)  gain register index
- `gain_data`  in  N  signed gain, Q`magn`.`decim`
- `DataOut`  out  N  mixed, saturated sample, signed
- `data_valid`  out  1  one-cycle pulse when `DataOut` updates
- `busy`  out  1  high while a mix is in progress
- `overrun`  out  1  sticky: `gen_enable` arrived while busy

## Operation
- Gain file: NBANDS×N registers. Reset value is unity, `1<<decim` (0x004000).
  - A write occurs on `gain_we`. Writes with `gain_addr ≥ NBANDS` are ignored.
- FSM states: IDLE → MAC → SAT → IDLE.
- IDLE:
  - On `gen_enable`, latch all of `DataBands` and a snapshot of every gain.
  - Clear the accumulator. Set index k=0 and go to MAC.
- MAC: each cycle, acc += band[k]*gain[k] at full precision.
  - Product width is 2N. Accumulator width is 2N+clog2(NBANDS), so it cannot overflow.
  - After k=NBANDS-1, go to SAT.
- SAT:
  - r = acc >>> decim (arithmetic shift, i.e. truncation toward −∞).
  - Clamp r to [−2^(N−1), 2^(N−1)−1].
  - Register the result into `DataOut`, pulse `data_valid`, return to IDLE.
- Gain writes during MAC/SAT update the gain file only. The running mix uses the snapshot, and the new gain applies from the next strobe.
- A write on the same cycle as an accepted `gen_enable` is not in the snapshot. The snapshot takes the pre-write value.
- `gen_enable` while `busy`: the strobe is dropped, the current mix completes unchanged, and `overrun` is set. `overrun` clears only on `reset`.
- `reset` mid-mix: the mix is aborted and no `data_valid` is produced. The FSM returns to IDLE and gains return to unity.

## Timing
- Reset values:
  - `DataOut`=0, `data_valid`=0, `busy`=0, `overrun`=0.
  - FSM=IDLE, accumulator=0, all gains=0x004000.
- Cycle of `gen_enable`: capture happens. `busy` rises the following cycle.
- Latency: with `gen_enable` high in cycle t, `DataOut` and `data_valid` appear in cycle t+NBANDS+2, which is t+6 for the default NBANDS=4.
- `busy` is high for cycles t+1 … t+NBANDS+1. It is low in the `data_valid` cycle, so a strobe in that cycle is accepted.
- `DataOut` holds its value between `data_valid` pulses.
- Minimum strobe spacing is NBANDS+2 cycles. The real sample rate is far slower.

## Structure
- Shared package (`eq_pkg`) holds:
  - default `decim`/`magn`/`N`
  - `UNITY_GAIN = 1<<decim`
  - the saturation limit constants
  - the FSM state enum
- One natural sub-module, `sat_shift`: combinational arithmetic shift by `decim` plus clamp to N bits. It is reusable by the filters' output path.
- Gain file, FSM and MAC datapath stay in `band_gain_mixer`.

## Test plan
All cases use the defaults (N=23, decim=14, NBANDS=4).
1. Reset, then bands {0x001000, 0x002000, 0x000800, 0x000400} at unity gains, strobe → `DataOut`=0x003C00 with `data_valid` exactly 6 cycles after the strobe.
2. Gains {0x008000, 0x002000, 0, 0x004000}, bands all 0x004000 → `DataOut`=0x00E000 (2+0.5+0+1 = 3.5).
3. Saturation:
   - bands all 0x3FFFFF at gain 0x3FFFFF → `DataOut`=0x3FFFFF.
   - bands all 0x400000 at gain 0x004000 → `DataOut`=0x400000 (−2^22).
4. Truncation: band0 = −1 (0x7FFFFF), gain0 = 0x002000, other gains 0 → `DataOut`=0x7FFFFF (−1, floor), not 0.
5. Strobe issued 2 cycles after an accepted strobe → second strobe ignored, first result correct, `overrun`=1 and stays 1 until `reset`.
6. Gain write to band 1 during MAC → current output uses the old gain, next strobe uses the new one. `reset` asserted in MAC cycle 2 → no `data_valid`, and `DataOut`=0 on the next cycle.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared equalizer definitions: default sample format, unity gain, saturation
// limits for the default width and the mixer FSM state encoding.
package eq_pkg;

  localparam int unsigned DECIM = 14;                 // fractional bits
  localparam int unsigned MAGN  = 8;                  // integer bits
  localparam int unsigned NW    = DECIM + MAGN + 1;   // sample/gain width

  localparam logic [NW-1:0] UNITY_GAIN = NW'(1) << DECIM;
  localparam logic [NW-1:0] SAT_MAX    = {1'b0, {(NW-1){1'b1}}};
  localparam logic [NW-1:0] SAT_MIN    = {1'b1, {(NW-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StSat
  } mix_state_e;

endpackage

// File: rtl/sat_shift.sv
// Combinational fixed-point rescale: arithmetic shift right by decim (floor)
// then clamp into the signed N-bit range.
// Ports:
//   din  - wide signed accumulator value (IW bits)
//   dout - saturated signed N-bit result
module sat_shift
  import eq_pkg::*;
#(
  parameter int unsigned IW    = 2 * NW + 2,
  parameter int unsigned N     = NW,
  parameter int unsigned decim = DECIM
) (
  input  logic signed [IW-1:0] din,
  output logic signed [N-1:0]  dout
);

  // Limits expressed at the input width so the compare is a plain signed one.
  localparam logic signed [IW-1:0] MaxV = {{(IW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [IW-1:0] MinV = {{(IW-N+1){1'b1}}, {(N-1){1'b0}}};

  logic signed [IW-1:0] shifted;

  always_comb begin
    shifted = din >>> decim;
    if (shifted > MaxV) begin
      dout = MaxV[N-1:0];
    end else if (shifted < MinV) begin
      dout = MinV[N-1:0];
    end else begin
      dout = shifted[N-1:0];
    end
  end

endmodule

// File: rtl/band_gain_mixer.sv
// Equalizer output stage. On each sample strobe it captures all band outputs
// and a snapshot of the gain file, then multiplies-and-accumulates one band per
// cycle with a single multiplier, and finally rescales/saturates to N bits.
// Ports:
//   clock, reset         - rising-edge clock, synchronous active-high reset
//   gen_enable           - sample strobe (one-cycle pulse)
//   DataBands            - packed band samples, band k at [k*N +: N]
//   gain_we/addr/data    - gain register write port (Q magn.decim)
//   DataOut, data_valid  - mixed saturated sample and its one-cycle strobe
//   busy                 - mix in progress (strobes are dropped)
//   overrun              - sticky: a strobe arrived while busy
module band_gain_mixer
  import eq_pkg::*;
#(
  parameter int unsigned decim  = DECIM,
  parameter int unsigned magn   = MAGN,
  parameter int unsigned N      = decim + magn + 1,
  parameter int unsigned NBANDS = 4,
  localparam int unsigned AW    = $clog2(NBANDS),
  localparam int unsigned AccW  = 2 * N + AW
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                gen_enable,
  input  logic [NBANDS*N-1:0] DataBands,
  input  logic                gain_we,
  input  logic [AW-1:0]       gain_addr,
  input  logic [N-1:0]        gain_data,
  output logic [N-1:0]        DataOut,
  output logic                data_valid,
  output logic                busy,
  output logic                overrun
);

  localparam logic signed [N-1:0] Unity  = N'(1) << decim;
  localparam logic [AW:0]         NbLim  = (AW+1)'(NBANDS);
  localparam logic [AW-1:0]       LastIx = AW'(NBANDS - 1);

  mix_state_e state_q, state_d;

  logic signed [N-1:0]    gain_q [NBANDS];
  logic signed [N-1:0]    snap_q [NBANDS];
  logic signed [N-1:0]    band_q [NBANDS];
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [N-1:0]           dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q;

  logic signed [2*N-1:0]  prod;
  logic signed [AccW-1:0] prod_ext;
  logic signed [N-1:0]    sat_out;

  logic accept;
  assign accept = (state_q == StIdle) && gen_enable;

  assign prod     = band_q[idx_q] * snap_q[idx_q];
  assign prod_ext = {{(AccW-2*N){prod[2*N-1]}}, prod};

  sat_shift #(
    .IW    (AccW),
    .N     (N),
    .decim (decim)
  ) u_sat_shift (
    .din  (acc_q),
    .dout (sat_out)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gen_enable) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + prod_ext;
        if (idx_q == LastIx) begin
          state_d = StSat;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StSat: begin
        dout_d  = sat_out;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      acc_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      if (gen_enable && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Capture registers. The snapshot reads gain_q before any same-cycle write
  // lands, so a write coinciding with the strobe applies from the next mix.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NBANDS; k++) begin
      if (reset) begin
        gain_q[k] <= Unity;
        snap_q[k] <= '0;
        band_q[k] <= '0;
      end else begin
        if (gain_we && ({1'b0, gain_addr} < NbLim) && (gain_addr == AW'(k))) begin
          gain_q[k] <= gain_data;
        end
        if (accept) begin
          snap_q[k] <= gain_q[k];
          band_q[k] <= DataBands[k*N +: N];
        end
      end
    end
  end

  assign DataOut    = dout_q;
  assign data_valid = valid_q;
  assign busy       = (state_q != StIdle);
  assign overrun    = overrun_q;

endmodule
